seq_rotate_unit: RTL and testbench

- Multi-cycle right-direction shift unit for the WISC-16 execute stage.
- Performs ROR (rotate right) and SRL (logical right shift) on a 16-bit operand, one bit position per clock.
- Complements the existing single-cycle SLL/SRA shifter; the ALU steers ROR/SRL opcodes here and stalls on busy.
- Uses a start/busy/done handshake with the pipeline stall logic.

---
 rtl/wisc_pkg.sv | 17 +
 rtl/rshift_step.sv | 22 ++
 rtl/seq_rotate_unit.sv | 70 +++++++
 tb/tb_seq_rotate_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared WISC-16 execute-stage definitions: shift mode encodings, the
// sequential shifter state type and default data-path widths.
package wisc_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_AMT_W = 4;

  localparam logic MODE_ROR = 1'b0;
  localparam logic MODE_SRL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : wisc_pkg

// File: rtl/rshift_step.sv
// One-position right step: rotate (ROR) or logical shift (SRL) of the working word.
module rshift_step
  import wisc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] work,
  input  logic             mode,
  output logic [WIDTH-1:0] stepped
);

  logic fill;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here a default first) so no latch is inferred.
  always_comb begin
    fill = work[0];
    if (mode == MODE_SRL) fill = 1'b0;
    stepped = {fill, work[WIDTH-1:1]};
  end

endmodule : rshift_step

// File: rtl/seq_rotate_unit.sv
// Multi-cycle ROR/SRL unit: one bit position per clock, start/busy/done handshake,
// abort for pipeline flush.
module seq_rotate_unit
  import wisc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amt,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_step;
  logic [AMT_W-1:0] cnt;
  logic             mode_q;
  logic             accept;

  rshift_step #(.WIDTH(WIDTH)) u_step (
    .work    (work),
    .mode    (mode_q),
    .stepped (work_step)
  );

  // Abort outranks start, so a flushed request is never latched.
  assign accept = start && !abort && (state == ST_IDLE || state == ST_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      work   <= '0;
      cnt    <= '0;
      mode_q <= 1'b0;
    end else if (abort) begin
      state <= ST_IDLE;
    end else if (accept) begin
      work   <= data_in;
      cnt    <= amt;
      mode_q <= mode;
      state  <= (amt != '0) ? ST_SHIFT : ST_DONE;
    end else begin
      case (state)
        ST_SHIFT: begin
          work <= work_step;
          cnt  <= cnt - 1'b1;
          // Exiting at 1 means cnt never decrements past zero.
          if (cnt == AMT_W'(1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (state == ST_SHIFT);
  assign done   = (state == ST_DONE);
  assign result = work;

endmodule : seq_rotate_unit

// File: tb/tb_seq_rotate_unit.sv
// Directed bench for seq_rotate_unit: inputs driven and outputs sampled on the falling edge.
module tb_seq_rotate_unit;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [AMT_W-1:0] amt = '0;
  logic             mode = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  int checks = 0;
  int failures = 0;

  seq_rotate_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .data_in (data_in),
    .amt     (amt),
    .mode    (mode),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  // Present a request at the falling edge; it is accepted on the next rising edge.
  task automatic drive_start(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a,
                             input logic m);
    start   = 1'b1;
    data_in = d;
    amt     = a;
    mode    = m;
  endtask

  // Runs a single op from idle, counting busy cycles up to a bounded done.
  task automatic run_op(input string name, input logic [WIDTH-1:0] d,
                        input logic [AMT_W-1:0] a, input logic m,
                        input logic [WIDTH-1:0] exp_result);
    int busy_cycles = 0;
    bit seen_done = 0;
    @(negedge clk);
    drive_start(d, a, m);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen_done = 1;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    checks++;
    if (!seen_done) begin
      failures++;
      $display("FAIL %s_done_timeout: done=0 required done=1 within 40 cycles", name);
    end else begin
      checks++;
      if (result !== exp_result) begin
        failures++;
        $display("FAIL %s_result: got %h required %h", name, result, exp_result);
      end
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL %s_busy_with_done: got %b required 0", name, busy);
      end
    end
    checks++;
    if (busy_cycles != int'(a)) begin
      failures++;
      $display("FAIL %s_busy_cycles: got %0d required %0d", name, busy_cycles, a);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_after: busy=%b done=%b required 0/0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000) begin
      failures++;
      $display("FAIL reset_hold: busy=%b done=%b result=%h required 0/0/0000", busy, done, result);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000) begin
      failures++;
      $display("FAIL reset_idle: busy=%b done=%b result=%h required 0/0/0000", busy, done, result);
    end
  endtask

  task automatic test_ror_srl();
    run_op("ror_8001_1", 16'h8001, 4'd1, 1'b0, 16'hC000);
    run_op("srl_8001_4", 16'h8001, 4'd4, 1'b1, 16'h0800);
    run_op("ror_1234_15", 16'h1234, 4'd15, 1'b0, 16'h2468);
    run_op("srl_ffff_15", 16'hFFFF, 4'd15, 1'b1, 16'h0001);
  endtask

  task automatic test_amt_zero();
    @(negedge clk);
    drive_start(16'h1234, 4'd0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== 16'h1234) begin
      failures++;
      $display("FAIL amt0_done: done=%b busy=%b result=%h required 1/0/1234", done, busy, result);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL amt0_single_pulse: done=%b busy=%b required 0/0", done, busy);
    end
  endtask

  task automatic test_start_ignored();
    @(negedge clk);
    drive_start(16'h00F0, 4'd4, 1'b0);
    @(negedge clk);
    drive_start(16'hFFFF, 4'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL ignore_busy_%0d: got %b required 1", i, busy);
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 16'h000F) begin
      failures++;
      $display("FAIL ignore_result: done=%b result=%h required 1/000F", done, result);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h000F) begin
      failures++;
      $display("FAIL ignore_hold: busy=%b done=%b result=%h required 0/0/000F", busy, done, result);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cycles = 0;
    @(negedge clk);
    drive_start(16'h00F0, 4'd1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || result !== 16'h0078) begin
      failures++;
      $display("FAIL b2b_first: done=%b result=%h required 1/0078", done, result);
    end
    drive_start(16'hFFFF, 4'd8, 1'b1);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_no_bubble: busy=%b required 1", busy);
    end
    for (int i = 0; i < 40 && !done; i++) begin
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || result !== 16'h00FF || busy_cycles != 8) begin
      failures++;
      $display("FAIL b2b_second: done=%b result=%h busy_cycles=%0d required 1/00FF/8",
               done, result, busy_cycles);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit saw_done = 0;
    @(negedge clk);
    drive_start(16'h0F0F, 4'd6, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: busy=%b done=%b required 0/0", busy, done);
    end
    for (int i = 0; i < 10; i++) begin
      if (done || busy) saw_done = 1;
      @(negedge clk);
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL abort_no_done: activity seen after abort, required none");
    end
  endtask

  task automatic test_reset_mid_op();
    bit saw_done = 0;
    @(negedge clk);
    drive_start(16'hA5A5, 4'd6, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000) begin
      failures++;
      $display("FAIL reset_async: busy=%b done=%b result=%h required 0/0/0000", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy || result !== 16'h0000) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL reset_no_done: activity seen after reset, required none");
    end
  endtask

  initial begin
    test_reset();
    test_ror_srl();
    test_amt_zero();
    test_start_ignored();
    test_back_to_back();
    test_abort();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seq_rotate_unit
